// File: rtl/data_mem_lsu.sv
// RV32 load/store data memory: byte/half/word accesses over a valid/ready request
// channel, one registered, stallable response per accepted request.
module data_mem_lsu #(
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_SIZE      = 64,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [2:0]               req_funct3,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int IDX_W = $clog2(MEM_SIZE);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              rsp_rdata_q, rsp_rdata_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic [31:0] mem_q [MEM_SIZE] = '{default: '0};

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             misaligned, illegal, req_err;
  logic             accept, consume, mem_we;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lanes, rd_word, load_data;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  // Upper address bits are deliberately ignored: accesses wrap modulo MEM_SIZE.
  if (ADDR_WIDTH > IDX_W + 2) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W+2];
  end

  assign idx     = req_addr[IDX_W+1:2];
  assign off     = req_addr[1:0];
  assign accept  = req_valid && req_ready;
  assign consume = rsp_valid && rsp_ready;
  assign req_err = misaligned || illegal;
  assign mem_we  = accept && req_we && !req_err;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (req_funct3)
      F3_B:  ;
      F3_H:  misaligned = off[0];
      F3_W:  misaligned = |off;
      F3_BU: illegal    = req_we;
      F3_HU: begin
        illegal    = req_we;
        misaligned = off[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = req_wdata;
    case (req_funct3)
      F3_B: begin
        byte_en     = 4'b0001 << off;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        byte_en     = off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: the array has no reset; contents survive rst_n and only lane writes touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[8*off +: 8];
  assign rd_half = rd_word[16*off[1] +: 16];

  always_comb begin
    load_data = rd_word;
    case (req_funct3)
      F3_B:  load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:  load_data = {{16{rd_half[15]}}, rd_half};
      F3_BU: load_data = {24'h0, rd_byte};
      F3_HU: load_data = {16'h0, rd_half};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Accept takes priority: accept+consume keeps the register full with no bubble.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      state_d     = S_FULL;
      rsp_err_d   = req_err;
      rsp_rdata_d = (req_err || req_we) ? 32'h0 : load_data;
      if (req_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end else if (consume) begin
      state_d = S_EMPTY;
    end
  end

  always_comb begin
    rsp_valid = (state_q == S_FULL);
    req_ready = !rsp_valid || rsp_ready;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
    err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: expected responses are queued at acceptance
// and compared in order when the DUT hands a response over.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b1;

  data_mem_lsu #(.ADDR_WIDTH(32), .MEM_SIZE(64), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; the request is held until accepted, expectation queued then.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
    else exp_q.push_back('{rdata: exp_d, err: exp_e});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then extended loads
    do_req(1, 32'h10, 32'h8765_4321, 3'b010, 32'h0, 0);
    do_req(0, 32'h11, 32'h0, 3'b000, 32'h0000_0043, 0);
    do_req(0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF87, 0);
    do_req(0, 32'h13, 32'h0, 3'b100, 32'h0000_0087, 0);
    do_req(0, 32'h12, 32'h0, 3'b001, 32'hFFFF_8765, 0);
    do_req(0, 32'h12, 32'h0, 3'b101, 32'h0000_8765, 0);
    do_req(0, 32'h10, 32'h0, 3'b010, 32'h8765_4321, 0);

    // Lane masking
    do_req(1, 32'h20, 32'hFFFF_FFFF, 3'b010, 32'h0, 0);
    do_req(1, 32'h22, 32'h5555_55AB, 3'b000, 32'h0, 0);
    do_req(1, 32'h20, 32'h5555_1234, 3'b001, 32'h0, 0);
    do_req(0, 32'h20, 32'h0, 3'b010, 32'hFFAB_1234, 0);

    // Misaligned / illegal requests
    do_req(1, 32'h21, 32'h1111_1111, 3'b010, 32'h0, 1);
    do_req(0, 32'h23, 32'h0, 3'b001, 32'h0, 1);
    do_req(0, 32'h20, 32'h0, 3'b011, 32'h0, 1);
    drain();
    check("err_cnt_3", 32'(err_cnt), 32'd3);
    do_req(0, 32'h20, 32'h0, 3'b010, 32'hFFAB_1234, 0);

    // Wrap-around
    do_req(1, 32'h100, 32'hDEAD_BEEF, 3'b010, 32'h0, 0);
    do_req(0, 32'h000, 32'h0, 3'b010, 32'hDEAD_BEEF, 0);
    drain();

    // Backpressure
    for (int i = 0; i < 4; i++) do_req(1, 32'h40 + 4*i, 32'hA0A0_0040 + 4*i, 3'b010, 32'h0, 0);
    drain();
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) do_req(0, 32'h40 + 4*i, 32'h0, 3'b010, 32'hA0A0_0040 + 4*i, 0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 3; k++) begin
          if (k != 0) @(negedge clk);
          check("bp_req_ready", 32'(req_ready), 32'd0);
          check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
          check("bp_rdata_hold", rsp_rdata, 32'hA0A0_0040);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_throughput", 32'(rsp_valid), 32'd1);
        end
      end
    join
    drain();

    // Error counter saturation (3 so far)
    for (int i = 0; i < 252; i++) do_req(i[0], 32'h50, 32'hFFFF_FFFF, i[0] ? 3'b011 : 3'b111, 32'h0, 1);
    drain();
    check("err_cnt_255", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 45; i++) do_req(1, 32'h52, 32'hFFFF_FFFF, 3'b110, 32'h0, 1);
    drain();
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    do_req(0, 32'h50, 32'h0, 3'b010, 32'h0, 0);
    drain();

    // Reset mid-operation
    do_req(1, 32'h30, 32'h5, 3'b010, 32'h0, 0);
    drain();
    mon_en = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rst_pre_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(rsp_valid), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h99; req_funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    rsp_ready = 1'b1;
    do_req(0, 32'h30, 32'h0, 3'b010, 32'h0000_0005, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
